// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller: FSM states and func_3 encodings.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP,
    FLUSH
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 010 and 011 are the only unused branch encodings
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/branch.sv
// Branch condition comparator; illegal encodings resolve to not-taken.
module branch
  import branch_pkg::*;
(
  input  logic        bena,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  func_3,
  output logic        take,
  output logic        illegal
);

  always_comb begin
    take    = 1'b0;
    illegal = bena & ~f3_legal(func_3);
    if (bena) begin
      case (func_3)
        F3_BEQ:  take = (rs1 == rs2);
        F3_BNE:  take = (rs1 != rs2);
        F3_BLT:  take = ($signed(rs1) <  $signed(rs2));
        F3_BGE:  take = ($signed(rs1) >= $signed(rs2));
        F3_BLTU: take = (rs1 <  rs2);
        F3_BGEU: take = (rs1 >= rs2);
        default: take = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accept, evaluate, redirect fetch, then flush.
// Define BRANCH_STATS_EN to add saturating stat_total / stat_taken counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  func_3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        kill,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall,
  output logic        done,
  output logic        taken,
  output logic        illegal,
  output logic        misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken
`endif
);

  localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] op_rs1, op_rs2, op_pc, op_imm;
  logic [2:0]  op_f3;
  logic        res_taken, res_illegal, res_mis;
  logic [31:0] res_target;
  logic        cmp_take, cmp_illegal;
  logic [31:0] target_calc;
  logic        need_redir;

  branch u_branch (
    .bena    (1'b1),
    .rs1     (op_rs1),
    .rs2     (op_rs2),
    .func_3  (op_f3),
    .take    (cmp_take),
    .illegal (cmp_illegal)
  );

  always_comb target_calc = op_pc + op_imm;

  // Outputs decode registered state; done/redirect also gate on kill and the
  // redirect handshake so the pulse lands on the handshake cycle itself.
  assign need_redir     = res_taken & ~res_mis;
  assign req_ready      = (state == IDLE) & ~kill;
  assign stall          = (state != IDLE);
  assign redirect_valid = (state == RESP) & need_redir & ~kill;
  assign redirect_pc    = res_target;
  assign done           = (state == RESP) & ~kill & (~need_redir | redirect_ready);
  assign taken          = done & res_taken;
  assign illegal        = done & res_illegal;
  assign misalign       = done & res_mis;
  assign flush          = (state == FLUSH) & ~kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_rs1      <= '0;
      op_rs2      <= '0;
      op_pc       <= '0;
      op_imm      <= '0;
      op_f3       <= '0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
      res_mis     <= 1'b0;
      res_target  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_rs1 <= rs1;
            op_rs2 <= rs2;
            op_pc  <= pc;
            op_imm <= imm;
            op_f3  <= func_3;
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            res_taken   <= cmp_take;
            res_illegal <= cmp_illegal;
            res_target  <= target_calc;
            res_mis     <= cmp_take & (target_calc[1:0] != 2'b00);
            state       <= RESP;
          end
        end
        RESP: begin
          if (kill || !need_redir) begin
            state <= IDLE;
          end else if (redirect_ready) begin
            if (FLUSH_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_INIT;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (kill || cnt == '0) state <= IDLE;
          else                   cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else begin
      if (done && stat_total != '1)  stat_total <= stat_total + 1'b1;
      if (taken && stat_taken != '1) stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected resolutions queued at accept, checked on done.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] rs1, rs2, pc, imm;
  logic [2:0]  func_3;
  logic        kill;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, stall, done, taken, illegal, misalign;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic        tk;
    logic        il;
    logic        ms;
    logic        rd;
    logic [31:0] tgt;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .func_3         (func_3),
    .pc             (pc),
    .imm            (imm),
    .kill           (kill),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall),
    .done           (done),
    .taken          (taken),
    .illegal        (illegal),
    .misalign       (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_take(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drives a request until accepted; returns the accept cycle, leaves cyc at n+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im, input int rr_delay,
                       input bit push, output int n);
    exp_t e;
    bit   acc;
    acc = 1'b0;
    n   = -1;
    func_3 = f; rs1 = a; rs2 = b; pc = p; imm = im;
    req_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (req_ready) begin
        acc = 1'b1;
        n   = cyc;
      end else begin
        step();
      end
    end
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.tk  = model_take(f, a, b);
      e.il  = (f == 3'b010) || (f == 3'b011);
      e.tgt = p + im;
      e.ms  = e.tk && (e.tgt[1:0] != 2'b00);
      e.rd  = e.tk && !e.ms;
      e.cyc = n + 2 + (e.rd ? rr_delay : 0);
      sbq.push_back(e);
    end
    step();
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid) begin
        if (sbq.size() == 0) begin
          check("spur_redirect", 32'(redirect_valid), 32'd0);
        end else begin
          check("redirect_expected", 32'd1, 32'(sbq[0].rd));
          check("redirect_pc", redirect_pc, sbq[0].tgt);
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          check("spur_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("taken", 32'(taken), 32'(e.tk));
          check("illegal", 32'(illegal), 32'(e.il));
          check("misalign", 32'(misalign), 32'(e.ms));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; redirect_ready = 1'b1;
    rs1 = '0; rs2 = '0; pc = '0; imm = '0; func_3 = '0;
    repeat (3) step();

    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    step();

    // beq taken, immediate redirect_ready: flush two cycles, ready again at N+5
    issue(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1'b1, n);
    for (int c = n + 1; c <= n + 5; c++) begin
      check("beq_cycle", 32'(cyc), 32'(c));
      check("beq_flush", 32'(flush), 32'((c == n + 3) || (c == n + 4)));
      check("beq_req_ready", 32'(req_ready), 32'(c == n + 5));
      if (c == n + 2) check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
      if (c < n + 5) step();
    end

    // blt signed: -1 < 1 taken
    issue(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 1'b1, n);
    // bltu same operands: not taken, ready again at N+3
    issue(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 0, 1'b1, n);
    step();
    check("bltu_redirect_valid", 32'(redirect_valid), 32'd0);
    check("bltu_busy", 32'(req_ready), 32'd0);
    step();
    check("bltu_ready_n3", 32'(req_ready), 32'd1);

    // illegal encoding
    issue(3'b010, 32'd3, 32'd3, 32'h400, 32'h8, 0, 1'b1, n);
    step();
    check("illegal_no_redirect", 32'(redirect_valid), 32'd0);
    step();

    // redirect back-pressure: three stalled cycles then handshake
    redirect_ready = 1'b0;
    issue(F3_BEQ, 32'd9, 32'd9, 32'h500, 32'h10, 3, 1'b1, n);
    for (int c = n + 2; c <= n + 5; c++) begin
      step();
      if (c == n + 5) redirect_ready = 1'b1;
      #1;
      check("bp_redirect_valid", 32'(redirect_valid), 32'd1);
      check("bp_redirect_pc", redirect_pc, 32'h510);
      check("bp_done", 32'(done), 32'(c == n + 5));
    end

    // kill during FLUSH
    issue(F3_BNE, 32'd1, 32'd2, 32'h600, 32'h4, 0, 1'b1, n);
    while (cyc < n + 3) step();
    kill = 1'b1;
    #1;
    check("kill_flush_gated", 32'(flush), 32'd0);
    step();
    kill = 1'b0;
    #1;
    check("kill_flush_idle", 32'(req_ready), 32'd1);
    check("kill_flush_stall", 32'(stall), 32'd0);
    check("kill_flush_flush", 32'(flush), 32'd0);

    // kill in RESP together with redirect_ready drops the redirect
    issue(F3_BEQ, 32'd7, 32'd7, 32'h700, 32'h8, 0, 1'b0, n);
    step();
    kill = 1'b1;
    #1;
    check("kill_resp_redirect", 32'(redirect_valid), 32'd0);
    check("kill_resp_done", 32'(done), 32'd0);
    step();
    kill = 1'b0;
    #1;
    check("kill_resp_idle", 32'(req_ready), 32'd1);
    check("kill_resp_flush", 32'(flush), 32'd0);

    // reset asserted while waiting in RESP
    redirect_ready = 1'b0;
    issue(F3_BEQ, 32'd2, 32'd2, 32'h800, 32'hC, 0, 1'b0, n);
    step();
    check("rst_resp_pre", 32'(redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_redirect", 32'(redirect_valid), 32'd0);
    check("rst_resp_stall", 32'(stall), 32'd0);
    step();
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    #1;
    check("rst_resp_ready", 32'(req_ready), 32'd1);
    check("rst_resp_flush", 32'(flush), 32'd0);
    check("rst_resp_done", 32'(done), 32'd0);
    repeat (3) step();

    // wrapped, misaligned target: taken but no redirect
    issue(F3_BEQ, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h12, 0, 1'b1, n);
    step();
    check("mis_redirect_valid", 32'(redirect_valid), 32'd0);
    check("mis_flag", 32'(misalign), 32'd1);
    step();
    check("mis_ready_n3", 32'(req_ready), 32'd1);

    // random mix over all encodings
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b, p, im;
      logic [2:0]  f;
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      p  = $urandom & 32'hFFFF_FFFC;
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      issue(f, a, b, p, im, 0, 1'b1, n);
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
    check("scoreboard_drain", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
